alu_control_sequencer: RTL and testbench

- Hardwired control unit that replaces the hand-driven stimulus used to exercise `Datapath`.
- Owns the instruction register and a five-step fetch/decode/execute/write-back state machine.
- Drives every `Datapath` control input for ALU-class instructions: register-register, register-immediate and unary.
- Stops permanently on HALT or on an unsupported opcode.

---
 rtl/alu_control_sequencer.sv | 251 +++++++++++++++++++++++++
 tb/tb_alu_control_sequencer.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_control_sequencer.sv
// rtl/alu_control_sequencer.sv - hardwired fetch/decode/execute/write-back control unit for Datapath
//
// Purpose:
//   Owns the instruction register and a five-step sequencer (T0..T4) that drives
//   every Datapath control input for ALU-class instructions (R-type, I-type, unary).
//   Stops permanently in HALT on a HALT opcode or an unsupported opcode.
//
// Ports:
//   iClk, nRst          clock (rising edge), asynchronous active-low reset
//   iRun                issue instructions back to back while high
//   oBusy/oHalted/oIllegal/oRetired  host status
//   iMemData            instruction word, captured into IR at the end of T0
//   oPC_*               program-counter control
//   oRF_*               register-file write enable and A/B/C addresses
//   oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en  datapath register enables
//   oALU_Ctrl           ALU operation select
//   oMUX_*              datapath mux selects
//   oImm32              sign-extended immediate (non-zero only in T2 of an I-type)

package alu_isa_pkg;
    localparam logic [4:0] OP_ADD  = 5'h00;
    localparam logic [4:0] OP_SUB  = 5'h01;
    localparam logic [4:0] OP_AND  = 5'h02;
    localparam logic [4:0] OP_OR   = 5'h03;
    localparam logic [4:0] OP_SHL  = 5'h04;
    localparam logic [4:0] OP_SHR  = 5'h05;
    localparam logic [4:0] OP_ADDI = 5'h06;
    localparam logic [4:0] OP_ANDI = 5'h07;
    localparam logic [4:0] OP_ORI  = 5'h08;
    localparam logic [4:0] OP_NEG  = 5'h09;
    localparam logic [4:0] OP_NOT  = 5'h0A;
    localparam logic [4:0] OP_HALT = 5'h1F;

    localparam logic [3:0] ALU_ADD = 4'h0;
    localparam logic [3:0] ALU_SUB = 4'h1;
    localparam logic [3:0] ALU_AND = 4'h2;
    localparam logic [3:0] ALU_OR  = 4'h3;
    localparam logic [3:0] ALU_SHL = 4'h4;
    localparam logic [3:0] ALU_SHR = 4'h5;
    localparam logic [3:0] ALU_NEG = 4'h6;
    localparam logic [3:0] ALU_NOT = 4'h7;
endpackage

module alu_control_sequencer
    import alu_isa_pkg::*;
(
    input  logic        iClk,
    input  logic        nRst,
    input  logic        iRun,
    output logic        oBusy,
    output logic        oHalted,
    output logic        oIllegal,
    output logic [31:0] oRetired,
    input  logic [31:0] iMemData,
    output logic        oPC_nRst,
    output logic        oPC_en,
    output logic        oPC_jmp,
    output logic        oPC_loadRA,
    output logic        oPC_loadImm,
    output logic        oRF_Write,
    output logic [3:0]  oRF_AddrA,
    output logic [3:0]  oRF_AddrB,
    output logic [3:0]  oRF_AddrC,
    output logic        oRWB_en,
    output logic        oRA_en,
    output logic        oRB_en,
    output logic        oRZH_en,
    output logic        oRZL_en,
    output logic        oRAS_en,
    output logic [3:0]  oALU_Ctrl,
    output logic        oMUX_BIS,
    output logic        oMUX_RZHS,
    output logic        oMUX_WBM,
    output logic        oMUX_WBP,
    output logic        oMUX_MAP,
    output logic        oMUX_ASS,
    output logic [31:0] oImm32
);

    typedef enum logic [2:0] {
        S_RESET,
        S_IDLE,
        S_T0,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_HALT
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [31:0] r_ir;
    logic [31:0] r_retired;
    logic        r_illegal;

    logic [4:0]  w_op;
    logic [3:0]  w_ra;
    logic [3:0]  w_rb;
    logic [3:0]  w_rc;
    logic [18:0] w_imm19;
    logic        w_is_r;
    logic        w_is_i;
    logic        w_is_u;
    logic        w_is_halt;
    logic [3:0]  w_alu_op;

    assign w_op    = r_ir[31:27];
    assign w_ra    = r_ir[26:23];
    assign w_rb    = r_ir[22:19];
    assign w_rc    = r_ir[18:15];
    assign w_imm19 = r_ir[18:0];

    // Opcode class and ALU mapping; anything not listed falls out as illegal.
    always_comb begin
        w_is_r    = 1'b0;
        w_is_i    = 1'b0;
        w_is_u    = 1'b0;
        w_is_halt = 1'b0;
        w_alu_op  = ALU_ADD;
        case (w_op)
            OP_ADD:  begin w_is_r = 1'b1; w_alu_op = ALU_ADD; end
            OP_SUB:  begin w_is_r = 1'b1; w_alu_op = ALU_SUB; end
            OP_AND:  begin w_is_r = 1'b1; w_alu_op = ALU_AND; end
            OP_OR:   begin w_is_r = 1'b1; w_alu_op = ALU_OR;  end
            OP_SHL:  begin w_is_r = 1'b1; w_alu_op = ALU_SHL; end
            OP_SHR:  begin w_is_r = 1'b1; w_alu_op = ALU_SHR; end
            OP_ADDI: begin w_is_i = 1'b1; w_alu_op = ALU_ADD; end
            OP_ANDI: begin w_is_i = 1'b1; w_alu_op = ALU_AND; end
            OP_ORI:  begin w_is_i = 1'b1; w_alu_op = ALU_OR;  end
            OP_NEG:  begin w_is_u = 1'b1; w_alu_op = ALU_NEG; end
            OP_NOT:  begin w_is_u = 1'b1; w_alu_op = ALU_NOT; end
            OP_HALT: w_is_halt = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_RESET: w_next_state = S_IDLE;
            S_IDLE:  w_next_state = iRun ? S_T0 : S_IDLE;
            S_T0:    w_next_state = S_T1;
            S_T1:    w_next_state = (w_is_r || w_is_i || w_is_u) ? S_T2 : S_HALT;
            S_T2:    w_next_state = S_T3;
            S_T3:    w_next_state = S_T4;
            S_T4:    w_next_state = iRun ? S_T0 : S_IDLE;
            S_HALT:  w_next_state = S_HALT;
            default: w_next_state = S_RESET;
        endcase
    end

    always_ff @(posedge iClk or negedge nRst) begin
        if (!nRst) begin
            r_state   <= S_RESET;
            r_ir      <= 32'd0;
            r_retired <= 32'd0;
            r_illegal <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_T0) begin
                r_ir <= iMemData;
            end
            if (r_state == S_T4) begin
                r_retired <= r_retired + 32'd1;
            end
            if (r_state == S_T1 && !(w_is_r || w_is_i || w_is_u || w_is_halt)) begin
                r_illegal <= 1'b1;
            end
        end
    end

    // Branch-related controls are never used by ALU-class instructions.
    assign oPC_jmp     = 1'b0;
    assign oPC_loadRA  = 1'b0;
    assign oPC_loadImm = 1'b0;
    assign oRAS_en     = 1'b0;
    assign oRetired    = r_retired;

    // Moore decode of state and IR. RESET decodes to all-zero so that an
    // asserted nRst forces every output low immediately (aborting a T4 write).
    always_comb begin
        oBusy     = 1'b0;
        oHalted   = 1'b0;
        oIllegal  = 1'b0;
        oPC_nRst  = 1'b1;
        oPC_en    = 1'b0;
        oRF_Write = 1'b0;
        oRF_AddrA = 4'd0;
        oRF_AddrB = 4'd0;
        oRF_AddrC = 4'd0;
        oRWB_en   = 1'b0;
        oRA_en    = 1'b0;
        oRB_en    = 1'b0;
        oRZH_en   = 1'b0;
        oRZL_en   = 1'b0;
        oALU_Ctrl = 4'd0;
        oMUX_BIS  = 1'b0;
        oMUX_RZHS = 1'b0;
        oMUX_WBM  = 1'b0;
        oMUX_WBP  = 1'b0;
        oMUX_MAP  = 1'b0;
        oMUX_ASS  = 1'b0;
        oImm32    = 32'd0;
        case (r_state)
            S_RESET: oPC_nRst = 1'b0;
            S_IDLE:  ;
            S_T0: begin
                oBusy    = 1'b1;
                oMUX_MAP = 1'b1;
                oPC_en   = 1'b1;
            end
            S_T1: begin
                oBusy = 1'b1;
                if (w_is_r || w_is_i || w_is_u) begin
                    oRF_AddrA = w_rb;
                    oRA_en    = 1'b1;
                end
                if (w_is_r) begin
                    oRF_AddrB = w_rc;
                    oRB_en    = 1'b1;
                end
            end
            S_T2: begin
                oBusy     = 1'b1;
                oALU_Ctrl = w_alu_op;
                oRZH_en   = 1'b1;
                oRZL_en   = 1'b1;
                if (w_is_i) begin
                    oMUX_BIS = 1'b1;
                    oImm32   = {{13{w_imm19[18]}}, w_imm19};
                end
            end
            S_T3: begin
                oBusy   = 1'b1;
                oRWB_en = 1'b1;
            end
            S_T4: begin
                oBusy     = 1'b1;
                oRF_AddrC = w_ra;
                oRF_Write = 1'b1;
            end
            S_HALT: begin
                oHalted  = 1'b1;
                oIllegal = r_illegal;
            end
            default: oPC_nRst = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_alu_control_sequencer.sv
// tb/tb_alu_control_sequencer.sv - self-checking bench for alu_control_sequencer with a datapath plant
module tb_alu_control_sequencer;
    import alu_isa_pkg::*;

    logic        iClk;
    logic        nRst;
    logic        iRun;
    logic        oBusy, oHalted, oIllegal;
    logic [31:0] oRetired;
    logic [31:0] iMemData;
    logic        oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm;
    logic        oRF_Write;
    logic [3:0]  oRF_AddrA, oRF_AddrB, oRF_AddrC;
    logic        oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en;
    logic [3:0]  oALU_Ctrl;
    logic        oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_MAP, oMUX_ASS;
    logic [31:0] oImm32;

    alu_control_sequencer dut (
        .iClk(iClk), .nRst(nRst), .iRun(iRun),
        .oBusy(oBusy), .oHalted(oHalted), .oIllegal(oIllegal), .oRetired(oRetired),
        .iMemData(iMemData),
        .oPC_nRst(oPC_nRst), .oPC_en(oPC_en), .oPC_jmp(oPC_jmp),
        .oPC_loadRA(oPC_loadRA), .oPC_loadImm(oPC_loadImm),
        .oRF_Write(oRF_Write), .oRF_AddrA(oRF_AddrA), .oRF_AddrB(oRF_AddrB), .oRF_AddrC(oRF_AddrC),
        .oRWB_en(oRWB_en), .oRA_en(oRA_en), .oRB_en(oRB_en),
        .oRZH_en(oRZH_en), .oRZL_en(oRZL_en), .oRAS_en(oRAS_en),
        .oALU_Ctrl(oALU_Ctrl),
        .oMUX_BIS(oMUX_BIS), .oMUX_RZHS(oMUX_RZHS), .oMUX_WBM(oMUX_WBM),
        .oMUX_WBP(oMUX_WBP), .oMUX_MAP(oMUX_MAP), .oMUX_ASS(oMUX_ASS),
        .oImm32(oImm32)
    );

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    // Datapath plant: register file and operand/result registers steered by the DUT.
    logic [31:0] rf [16];
    logic [31:0] dp_a, dp_b, dp_z, dp_wb;
    logic        tb_load;
    logic [3:0]  tb_ld_addr;
    logic [31:0] tb_ld_data;

    function automatic logic [31:0] plant_alu(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
        case (c)
            ALU_ADD: return a + b;
            ALU_SUB: return a - b;
            ALU_AND: return a & b;
            ALU_OR:  return a | b;
            ALU_SHL: return a << b[4:0];
            ALU_SHR: return a >> b[4:0];
            ALU_NEG: return 32'd0 - a;
            ALU_NOT: return ~a;
            default: return 32'hDEAD_BEEF;
        endcase
    endfunction

    always @(posedge iClk) begin
        if (tb_load) rf[tb_ld_addr] <= tb_ld_data;
        else if (oRF_Write) rf[oRF_AddrC] <= dp_wb;
        if (oRA_en)  dp_a  <= rf[oRF_AddrA];
        if (oRB_en)  dp_b  <= rf[oRF_AddrB];
        if (oRZL_en) dp_z  <= plant_alu(oALU_Ctrl, dp_a, oMUX_BIS ? oImm32 : dp_b);
        if (oRWB_en) dp_wb <= dp_z;
    end

    // Reference model: instruction semantics on a plain register array.
    logic [31:0] ref_rf [16];
    logic [31:0] exp_retired;
    logic        pending;
    logic [3:0]  p_ra;
    int          n_chk;
    int          n_err;

    function automatic logic [31:0] ref_result(input logic [31:0] ins, input logic [31:0] b, input logic [31:0] c);
        logic [31:0] simm;
        simm = 32'($signed(ins[18:0]));
        case (ins[31:27])
            OP_ADD:  return b + c;
            OP_SUB:  return b - c;
            OP_AND:  return b & c;
            OP_OR:   return b | c;
            OP_SHL:  return b << c[4:0];
            OP_SHR:  return b >> c[4:0];
            OP_ADDI: return b + simm;
            OP_ANDI: return b & simm;
            OP_ORI:  return b | simm;
            OP_NEG:  return -b;
            OP_NOT:  return ~b;
            default: return 32'hBAD0_BAD0;
        endcase
    endfunction

    function automatic logic is_r(input logic [4:0] op);
        return op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR};
    endfunction

    function automatic logic is_i(input logic [4:0] op);
        return op inside {OP_ADDI, OP_ANDI, OP_ORI};
    endfunction

    function automatic logic [3:0] alu_of(input logic [4:0] op);
        case (op)
            OP_ADD, OP_ADDI: return ALU_ADD;
            OP_SUB:          return ALU_SUB;
            OP_AND, OP_ANDI: return ALU_AND;
            OP_OR, OP_ORI:   return ALU_OR;
            OP_SHL:          return ALU_SHL;
            OP_SHR:          return ALU_SHR;
            OP_NEG:          return ALU_NEG;
            default:         return ALU_NOT;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Bit order: PC_nRst PC_en PC_jmp loadRA loadImm RF_Write RWB RA RB RZH RZL RAS
    //            BIS RZHS WBM WBP MAP ASS Busy Halted Illegal
    function automatic logic [31:0] ctl_word();
        return {11'd0, oPC_nRst, oPC_en, oPC_jmp, oPC_loadRA, oPC_loadImm, oRF_Write,
                oRWB_en, oRA_en, oRB_en, oRZH_en, oRZL_en, oRAS_en,
                oMUX_BIS, oMUX_RZHS, oMUX_WBM, oMUX_WBP, oMUX_MAP, oMUX_ASS,
                oBusy, oHalted, oIllegal};
    endfunction

    localparam int B_NRST = 20, B_PCEN = 19, B_WR = 15, B_RWB = 14, B_RA = 13, B_RB = 12;
    localparam int B_RZH = 11, B_RZL = 10, B_BIS = 8, B_MAP = 4, B_BUSY = 2, B_HALT = 1, B_ILL = 0;

    task automatic check_zero(input string tag);
        chk({tag, "_ctl"}, ctl_word(), 32'd0);
        chk({tag, "_addr"}, {20'd0, oRF_AddrA, oRF_AddrB, oRF_AddrC}, 32'd0);
        chk({tag, "_alu"}, {28'd0, oALU_Ctrl}, 32'd0);
        chk({tag, "_imm"}, oImm32, 32'd0);
        chk({tag, "_ret"}, oRetired, 32'd0);
    endtask

    task automatic check_pending();
        if (pending) begin
            chk($sformatf("rf_R%0d", p_ra), rf[p_ra], ref_rf[p_ra]);
            pending = 1'b0;
        end
    endtask

    task automatic check_idle(input string tag);
        logic [31:0] e;
        e = 32'd0;
        e[B_NRST] = 1'b1;
        chk({tag, "_ctl"}, ctl_word(), e);
        chk({tag, "_ret"}, oRetired, exp_retired);
    endtask

    // Called at a negedge. nRst is held across one rising edge, then released;
    // the following rising edge moves RESET to IDLE.
    task automatic do_reset();
        iRun = 1'b0;
        nRst = 1'b0;
        #1;
        check_zero("rst");
        pending     = 1'b0;
        exp_retired = 32'd0;
        @(negedge iClk);
        nRst = 1'b1;
        @(negedge iClk);
        check_idle("post_rst");
    endtask

    task automatic load_reg(input logic [3:0] a, input logic [31:0] d);
        tb_load    = 1'b1;
        tb_ld_addr = a;
        tb_ld_data = d;
        @(negedge iClk);
        tb_load    = 1'b0;
        ref_rf[a]  = d;
    endtask

    task automatic wait_idle();
        @(negedge iClk);
        check_pending();
        check_idle("idle");
    endtask

    // Caller is at a negedge in IDLE or T4. Checks T0..T4 strobes one by one.
    task automatic run_instr(input logic [31:0] ins, input int drop_step,
                             input logic next_run, input logic abort);
        logic [4:0]  op;
        logic [31:0] e;
        logic [31:0] imm_e;
        op       = ins[31:27];
        iMemData = ins;
        iRun     = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge iClk);
            if (s == 0) check_pending();
            e = 32'd0;
            e[B_NRST] = 1'b1;
            e[B_BUSY] = 1'b1;
            imm_e = 32'd0;
            case (s)
                0: begin e[B_PCEN] = 1'b1; e[B_MAP] = 1'b1; end
                1: begin e[B_RA] = 1'b1; e[B_RB] = is_r(op); end
                2: begin
                    e[B_RZH] = 1'b1;
                    e[B_RZL] = 1'b1;
                    e[B_BIS] = is_i(op);
                    if (is_i(op)) imm_e = {{13{ins[18]}}, ins[18:0]};
                end
                3: e[B_RWB] = 1'b1;
                default: e[B_WR] = 1'b1;
            endcase
            chk($sformatf("T%0d_ctl", s), ctl_word(), e);
            chk($sformatf("T%0d_addrA", s), {28'd0, oRF_AddrA}, (s == 1) ? {28'd0, ins[22:19]} : 32'd0);
            chk($sformatf("T%0d_addrB", s), {28'd0, oRF_AddrB}, (s == 1 && is_r(op)) ? {28'd0, ins[18:15]} : 32'd0);
            chk($sformatf("T%0d_addrC", s), {28'd0, oRF_AddrC}, (s == 4) ? {28'd0, ins[26:23]} : 32'd0);
            chk($sformatf("T%0d_alu", s), {28'd0, oALU_Ctrl}, (s == 2) ? {28'd0, alu_of(op)} : 32'd0);
            chk($sformatf("T%0d_imm", s), oImm32, imm_e);
            chk($sformatf("T%0d_ret", s), oRetired, exp_retired);
            if (s == drop_step) iRun = 1'b0;
            if (s == 4) iRun = next_run;
        end
        if (abort) begin
            do_reset();
        end else begin
            ref_rf[ins[26:23]] = ref_result(ins, ref_rf[ins[22:19]], ref_rf[ins[18:15]]);
            exp_retired = exp_retired + 32'd1;
            pending     = 1'b1;
            p_ra        = ins[26:23];
        end
    endtask

    task automatic run_halt(input logic [31:0] ins, input logic exp_ill);
        logic [31:0] e;
        iMemData = ins;
        iRun     = 1'b1;
        @(negedge iClk);
        check_pending();
        @(negedge iClk);
        e = 32'd0;
        e[B_NRST] = 1'b1;
        e[B_BUSY] = 1'b1;
        chk("halt_T1_ctl", ctl_word(), e);
        for (int k = 0; k < 4; k++) begin
            @(negedge iClk);
            e = 32'd0;
            e[B_NRST] = 1'b1;
            e[B_HALT] = 1'b1;
            e[B_ILL]  = exp_ill;
            chk("halt_ctl", ctl_word(), e);
            chk("halt_ret", oRetired, exp_retired);
        end
    endtask

    function automatic logic [31:0] enc(input logic [4:0] op, input logic [3:0] ra,
                                        input logic [3:0] rb, input logic [18:0] low);
        return {op, ra, rb, low};
    endfunction

    logic [4:0]  legal_ops [11];
    logic [31:0] saved;
    logic [31:0] rnd;

    initial begin
        legal_ops = '{OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SHL, OP_SHR,
                      OP_ADDI, OP_ANDI, OP_ORI, OP_NEG, OP_NOT};
        n_chk = 0;
        n_err = 0;
        nRst = 1'b0;
        iRun = 1'b0;
        iMemData = 32'd0;
        tb_load = 1'b0;
        tb_ld_addr = 4'd0;
        tb_ld_data = 32'd0;
        pending = 1'b0;
        p_ra = 4'd0;
        exp_retired = 32'd0;
        @(negedge iClk);
        do_reset();

        for (int r = 0; r < 16; r++) load_reg(4'(r), $urandom);
        load_reg(4'd5, 32'h22);
        load_reg(4'd7, 32'h24);
        load_reg(4'd4, 32'h28);

        // Directed: ADD, ADDI with all-ones imm19, NEG in place.
        run_instr(enc(OP_ADD, 4'd3, 4'd5, {4'd7, 15'd0}), 5, 1'b1, 1'b0);
        run_instr(enc(OP_ADDI, 4'd2, 4'd4, 19'h7FFFF), 5, 1'b1, 1'b0);
        run_instr(enc(OP_NEG, 4'd5, 4'd5, 19'd0), 5, 1'b0, 1'b0);
        wait_idle();
        chk("add_R3", rf[3], 32'h46);
        chk("addi_R2", rf[2], 32'h27);
        chk("neg_R5", rf[5], 32'hFFFF_FFDE);
        chk("retired3", oRetired, 32'd3);

        // iRun dropped in T2: instruction completes, then IDLE.
        run_instr(enc(OP_SUB, 4'd9, 4'd2, {4'd3, 15'd0}), 2, 1'b0, 1'b0);
        wait_idle();
        chk("drop_busy", {31'd0, oBusy}, 32'd0);

        // Randomized back-to-back stream.
        for (int i = 0; i < 40; i++) begin
            rnd = $urandom;
            run_instr(enc(legal_ops[$urandom_range(0, 10)], rnd[3:0], rnd[7:4], rnd[26:8]),
                      5, (i < 39) ? 1'b1 : 1'b0, 1'b0);
        end
        wait_idle();
        chk("rand_ret", oRetired, 32'd44);

        // Reset during T4: write aborted, destination unchanged, count cleared.
        saved = rf[6];
        run_instr(enc(OP_ADD, 4'd6, 4'd3, {4'd2, 15'd0}), 5, 1'b1, 1'b1);
        chk("abort_R6", rf[6], saved);
        chk("abort_ret", oRetired, 32'd0);

        // HALT after one retired instruction, then an unused opcode after reset.
        run_instr(enc(OP_OR, 4'd1, 4'd3, {4'd5, 15'd0}), 5, 1'b1, 1'b0);
        run_halt(enc(OP_HALT, 4'd8, 4'd1, 19'd0), 1'b0);
        chk("or_R1", rf[1], ref_rf[1]);
        pending = 1'b0;
        saved = rf[8];
        chk("halt_R8", rf[8], saved);
        @(negedge iClk);
        do_reset();
        run_halt(enc(5'h1E, 4'd8, 4'd1, 19'd0), 1'b1);
        chk("ill_R8", rf[8], saved);
        @(negedge iClk);
        do_reset();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
